// File: rtl/np_mem_loader.sv
// Unified program/data RAM for the np core: boots an image from the host,
// serves the core's combinational-read port, then streams results back after halt.
module np_mem_loader #(
  parameter int WIDTH      = 32,
  parameter int ADDRSIZE   = 12,
  parameter int DUMP_WORDS = 16,
  parameter int BOOT_HOLD  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [WIDTH-1:0]    ld_data,
  input  logic                ld_last,
  output logic                cpu_reset,
  input  logic [ADDRSIZE-1:0] cpu_address,
  input  logic                cpu_wr,
  input  logic [WIDTH-1:0]    cpu_data_out,
  output logic [WIDTH-1:0]    cpu_data_in,
  input  logic                cpu_halt,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [WIDTH-1:0]    dump_data,
  output logic [ADDRSIZE-1:0] dump_addr,
  output logic                dump_last,
  output logic [ADDRSIZE:0]   loaded_words,
  output logic                ovf,
  output logic                done
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int BW    = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;

  typedef enum logic [2:0] {LOAD, BOOT, RUN, DUMP, DONE} state_t;

  state_t              state;
  logic [ADDRSIZE-1:0] wptr;
  logic [ADDRSIZE-1:0] rptr;
  logic [BW-1:0]       boot_cnt;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic                ld_fire;
  logic                dump_fire;
  logic                core_we;

  // Handshake outputs are masked while reset is held low so the host never
  // sees a stale transfer from the state being abandoned.
  assign ld_ready    = reset && (state == LOAD);
  assign dump_valid  = reset && (state == DUMP);
  assign done        = reset && (state == DONE);
  assign cpu_reset   = !reset || (state != RUN);
  assign dump_addr   = rptr;
  assign dump_data   = mem[rptr];
  assign dump_last   = (rptr == ADDRSIZE'(DUMP_WORDS - 1));
  assign cpu_data_in = mem[cpu_address];

  assign ld_fire   = ld_valid && ld_ready;
  assign dump_fire = dump_valid && dump_ready;
  assign core_we   = reset && (state == RUN) && cpu_wr;

  // RAM is never cleared; loads and core stores can't coincide since they
  // belong to different states.
  always_ff @(posedge clk) begin
    if (ld_fire)
      mem[wptr] <= ld_data;
    else if (core_we)
      mem[cpu_address] <= cpu_data_out;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= LOAD;
      wptr         <= '0;
      rptr         <= '0;
      loaded_words <= '0;
      ovf          <= 1'b0;
      boot_cnt     <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_fire) begin
            wptr         <= wptr + ADDRSIZE'(1);
            loaded_words <= loaded_words + (ADDRSIZE + 1)'(1);
            if (ld_last) begin
              state <= BOOT;
            end else if (wptr == {ADDRSIZE{1'b1}}) begin
              // Image filled the whole RAM without a terminator.
              ovf   <= 1'b1;
              state <= BOOT;
            end
          end
        end
        BOOT: begin
          if (boot_cnt == BW'(BOOT_HOLD - 1)) begin
            boot_cnt <= '0;
            state    <= RUN;
          end else begin
            boot_cnt <= boot_cnt + BW'(1);
          end
        end
        RUN: begin
          if (cpu_halt)
            state <= DUMP;
        end
        DUMP: begin
          if (dump_fire) begin
            rptr <= rptr + ADDRSIZE'(1);
            if (dump_last)
              state <= DONE;
          end
        end
        DONE: state <= DONE;
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_np_mem_loader.sv
// Bench for np_mem_loader: table-driven load vectors, hand-written program and
// dump sequences, and randomized load/run/dump rounds against an array model.
module tb_np_mem_loader;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        reset, ld_valid, ld_last, cpu_wr, cpu_halt, dump_ready;
  logic [31:0] ld_data, cpu_data_out;
  logic [11:0] cpu_address;
  logic        ld_ready, cpu_reset, dump_valid, dump_last, ovf, done;
  logic [31:0] cpu_data_in, dump_data;
  logic [11:0] dump_addr;
  logic [12:0] loaded_words;

  logic        s_reset, s_ld_valid, s_ld_ready, s_cpu_reset, s_dump_valid, s_dump_last, s_ovf, s_done;
  logic [31:0] s_ld_data, s_cpu_data_in, s_dump_data;
  logic [3:0]  s_cpu_address, s_dump_addr;
  logic [4:0]  s_loaded_words;

  np_mem_loader dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .cpu_reset(cpu_reset),
    .cpu_address(cpu_address), .cpu_wr(cpu_wr), .cpu_data_out(cpu_data_out),
    .cpu_data_in(cpu_data_in), .cpu_halt(cpu_halt), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr),
    .dump_last(dump_last), .loaded_words(loaded_words), .ovf(ovf), .done(done)
  );

  np_mem_loader #(.ADDRSIZE(4)) dut_small (
    .clk(clk), .reset(s_reset), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready),
    .ld_data(s_ld_data), .ld_last(1'b0), .cpu_reset(s_cpu_reset),
    .cpu_address(s_cpu_address), .cpu_wr(1'b0), .cpu_data_out(32'h0),
    .cpu_data_in(s_cpu_data_in), .cpu_halt(1'b0), .dump_valid(s_dump_valid),
    .dump_ready(1'b0), .dump_data(s_dump_data), .dump_addr(s_dump_addr),
    .dump_last(s_dump_last), .loaded_words(s_loaded_words), .ovf(s_ovf), .done(s_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        exp_ready;
    logic [12:0] exp_loaded;
    logic        exp_cpu_reset;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs[12];
  int          n_vec = 0;
  int          n_mis = 0;
  int          model_ptr;
  logic [31:0] model_mem [DW];
  logic [31:0] image [$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One table row: drive for one cycle, check ready before the edge and state after it.
  task automatic applyStimulus(input vec_t v);
    reset    = v.rst_n;
    ld_valid = v.valid;
    ld_data  = v.data;
    ld_last  = v.last;
    #1 checkOutput("tbl_ld_ready", ld_ready, v.exp_ready);
    if (!v.rst_n) begin
      model_ptr = 0;
    end else if (v.valid && v.exp_ready) begin
      model_mem[model_ptr] = v.data;
      model_ptr++;
    end
    @(negedge clk);
    checkOutput("tbl_loaded_words", loaded_words, v.exp_loaded);
    checkOutput("tbl_cpu_reset", cpu_reset, v.exp_cpu_reset);
    checkOutput("tbl_ovf", ovf, v.exp_ovf);
  endtask

  task automatic resetDut();
    reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; dump_ready = 1'b0;
    cpu_wr = 1'b0; cpu_halt = 1'b0;
    #1;
    checkOutput("rst_ld_ready", ld_ready, 0);
    checkOutput("rst_dump_valid", dump_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cpu_reset", cpu_reset, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("post_rst_ld_ready", ld_ready, 1);
    checkOutput("post_rst_loaded", loaded_words, 0);
    checkOutput("post_rst_ovf", ovf, 0);
    checkOutput("post_rst_cpu_reset", cpu_reset, 1);
    checkOutput("post_rst_done", done, 0);
  endtask

  task automatic loadImage(input bit gaps);
    for (int i = 0; i < image.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_data  = image[i];
      ld_last  = (i == image.size() - 1);
      #1 checkOutput("load_ready", ld_ready, 1);
      model_mem[i] = image[i];
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checkOutput("load_count", loaded_words, image.size());
    checkOutput("load_ovf", ovf, 0);
  endtask

  // Counts edges with cpu_reset still high after the last load word; optionally
  // hammers the core write port meanwhile, which must not reach the RAM.
  task automatic waitRun(input bit junk);
    int c = 0;
    if (junk) begin
      cpu_wr = 1'b1; cpu_address = 12'd1; cpu_data_out = 32'hDEADBEEF;
    end
    while (cpu_reset && c < 10) begin
      @(negedge clk);
      c++;
    end
    cpu_wr = 1'b0;
    checkOutput("boot_hold_cycles", c, 2);
  endtask

  task automatic coreRandom(input int cycles);
    int a;
    for (int i = 0; i < cycles; i++) begin
      a = $urandom_range(0, DW - 1);
      cpu_address = 12'(a);
      cpu_wr = 1'b0;
      #1 checkOutput("core_read", cpu_data_in, model_mem[a]);
      if ($urandom_range(0, 1) == 1) begin
        cpu_wr = 1'b1;
        cpu_data_out = $urandom;
        model_mem[a] = cpu_data_out;
      end
      @(negedge clk);
    end
    cpu_wr = 1'b0;
  endtask

  task automatic haltCore(input bit with_write, input int a, input logic [31:0] d);
    cpu_halt = 1'b1;
    if (with_write) begin
      cpu_wr = 1'b1; cpu_address = 12'(a); cpu_data_out = d;
      model_mem[a] = d;
    end
    @(negedge clk);
    cpu_halt = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic dumpAndCheck(input int stall_at, input int reset_at, input bit rnd_stall);
    int n;
    for (int k = 0; k < DW; k++) begin
      checkOutput("dump_valid", dump_valid, 1);
      checkOutput("dump_addr", dump_addr, k);
      checkOutput("dump_last", dump_last, (k == DW - 1));
      checkOutput("dump_data", dump_data, model_mem[k]);
      if (k == reset_at) begin
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_dump_valid", dump_valid, 0);
        checkOutput("mid_rst_cpu_reset", cpu_reset, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("after_rst_ld_ready", ld_ready, 1);
        checkOutput("after_rst_loaded", loaded_words, 0);
        checkOutput("after_rst_dump_valid", dump_valid, 0);
        checkOutput("after_rst_cpu_reset", cpu_reset, 1);
        return;
      end
      n = (k == stall_at) ? 5 : (rnd_stall ? $urandom_range(0, 2) : 0);
      dump_ready = 1'b0;
      for (int j = 0; j < n; j++) begin
        @(negedge clk);
        checkOutput("stall_valid", dump_valid, 1);
        checkOutput("stall_addr", dump_addr, k);
        checkOutput("stall_data", dump_data, model_mem[k]);
      end
      dump_ready = 1'b1;
      @(negedge clk);
      dump_ready = 1'b0;
    end
    checkOutput("dump_done", done, 1);
    checkOutput("done_dump_valid", dump_valid, 0);
    checkOutput("done_cpu_reset", cpu_reset, 1);
  endtask

  task automatic smallOverflow();
    s_reset = 1'b0;
    @(negedge clk);
    s_reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_ld_valid = 1'b1;
      s_ld_data  = 32'(i);
      #1 checkOutput("ovf_ld_ready", s_ld_ready, (i < 16));
      @(negedge clk);
    end
    s_ld_valid = 1'b0;
    checkOutput("ovf_loaded", s_loaded_words, 16);
    checkOutput("ovf_flag", s_ovf, 1);
    checkOutput("ovf_boot_cpu_reset", s_cpu_reset, 1);
    @(negedge clk);
    checkOutput("ovf_run_cpu_reset", s_cpu_reset, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    cpu_wr = 1'b0; cpu_halt = 1'b0; cpu_address = '0; cpu_data_out = '0;
    dump_ready = 1'b0;
    s_reset = 1'b0; s_ld_valid = 1'b0; s_ld_data = '0; s_cpu_address = '0;
    model_ptr = 0;

    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 13'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'hA0A0A0A0, 1'b0, 1'b1, 13'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'hA1A1A1A1, 1'b0, 1'b1, 13'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'hA2A2A2A2, 1'b1, 1'b1, 13'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 13'd3, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 13'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 13'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'hB0B0B0B0, 1'b0, 1'b1, 13'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0BAD0BAD, 1'b0, 1'b1, 13'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'hB1B1B1B1, 1'b0, 1'b1, 13'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0BAD0BAD, 1'b0, 1'b1, 13'd2, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'hB2B2B2B2, 1'b1, 1'b1, 13'd3, 1'b1, 1'b0};

    repeat (3) @(negedge clk);

    // Random rounds; the first fills all dumped words so later dumps are fully known.
    for (int it = 0; it < 3; it++) begin
      resetDut();
      n = (it == 0) ? DW : $urandom_range(1, DW);
      image.delete();
      for (int i = 0; i < n; i++) image.push_back($urandom);
      loadImage(1'b1);
      waitRun(1'b0);
      coreRandom(20);
      haltCore(1'b1, $urandom_range(0, DW - 1), $urandom);
      dumpAndCheck(-1, -1, 1'b1);
    end

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    waitRun(1'b0);
    haltCore(1'b0, 0, 32'h0);
    dumpAndCheck(-1, -1, 1'b0);

    // LD R0,#5 / STR R0->[10] / HLT, with the bench standing in for the core.
    resetDut();
    image.delete();
    image.push_back(32'h38005000);
    image.push_back(32'h2000000A);
    image.push_back(32'hB0000000);
    loadImage(1'b0);
    waitRun(1'b1);
    cpu_address = 12'd0;
    #1 checkOutput("fetch0", cpu_data_in, 32'h38005000);
    @(negedge clk);
    cpu_address = 12'd1;
    #1 checkOutput("fetch1", cpu_data_in, 32'h2000000A);
    @(negedge clk);
    cpu_address = 12'd10; cpu_wr = 1'b1; cpu_data_out = 32'hFFFFFFFF;
    @(negedge clk);
    cpu_data_out = 32'h00000005;
    @(negedge clk);
    cpu_wr = 1'b0;
    model_mem[10] = 32'h00000005;
    #1 checkOutput("store_readback", cpu_data_in, 32'h00000005);
    cpu_address = 12'd2;
    #1 checkOutput("fetch2", cpu_data_in, 32'hB0000000);
    haltCore(1'b1, 11, 32'h12345678);
    dumpAndCheck(4, -1, 1'b0);

    // Reset in the middle of a dump, then confirm RAM survived it.
    resetDut();
    image.delete();
    image.push_back(32'h11111111);
    loadImage(1'b0);
    waitRun(1'b0);
    haltCore(1'b0, 0, 32'h0);
    dumpAndCheck(-1, 7, 1'b0);
    image.delete();
    image.push_back(32'h22222222);
    loadImage(1'b0);
    waitRun(1'b0);
    haltCore(1'b0, 0, 32'h0);
    dumpAndCheck(-1, -1, 1'b0);

    smallOverflow();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
